led_lighting_ctrl: RTL and testbench

- Generalised lighting controller that replaces the separate manual and automatic lighting blocks with one unit.
- Number of brightness levels, duty width and ADC width are parameters. Auto thresholds are runtime inputs and auto mode has hysteresis.
- Brightness changes fade linearly, and the block contains a glitch-free PWM generator.
- Sits between the button/switch inputs, the photo-sensor ADC and the LED pin. It is independent of the fan duty.

---
 rtl/led_lighting_ctrl.sv | 152 +++++++++++++++
 tb/tb_led_lighting_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_lighting_ctrl.sv
// Lighting controller: manual/auto brightness level selection with hysteresis,
// linear duty fading and a period-latched PWM output.
module led_lighting_ctrl #(
  parameter int unsigned DUTY_W     = 7,
  parameter int unsigned LEVELS     = 4,
  parameter int unsigned ADC_W      = 7,
  parameter int unsigned HYST       = 3,
  parameter int unsigned SAMPLE_DIV = 65536,
  parameter int unsigned FADE_DIV   = 1024,
  parameter int unsigned PWM_DIV    = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          btn,
  input  logic                          sw,
  input  logic [ADC_W-1:0]              adc_value,
  input  logic [(LEVELS-1)*ADC_W-1:0]   thr,
  output logic [$clog2(LEVELS)-1:0]     level,
  output logic [DUTY_W-1:0]             duty,
  output logic                          fading,
  output logic                          auto_mode,
  output logic                          led_pwm
);

  localparam int unsigned LW   = $clog2(LEVELS);
  localparam int unsigned NT   = LEVELS - 1;
  localparam int unsigned DMAX = (1 << DUTY_W) - 1;
  localparam int unsigned PW   = LW + DUTY_W;
  localparam int unsigned SCW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned FCW  = (FADE_DIV   > 1) ? $clog2(FADE_DIV)   : 1;
  localparam int unsigned PCW  = (PWM_DIV    > 1) ? $clog2(PWM_DIV)    : 1;

  logic              r_sw_s1, r_sw_s2;
  logic              r_auto;
  logic [ADC_W-1:0]  r_adc_s;
  logic [SCW-1:0]    r_scnt;
  logic [FCW-1:0]    r_fcnt;
  logic [PCW-1:0]    r_pdiv;
  logic [LW-1:0]     r_level;
  logic [DUTY_W-1:0] r_duty;
  logic              r_fading;
  logic [DUTY_W-1:0] r_pc;
  logic [DUTY_W-1:0] r_duty_l;
  logic              r_led;

  logic              w_stick;
  logic              w_fstep;
  logic              w_padv;
  logic              w_mode_chg;
  logic [LW:0]       w_up;
  logic [LW:0]       w_dn;
  logic [LW-1:0]     w_level_nxt;
  logic [DUTY_W-1:0] w_target;
  logic [DUTY_W-1:0] w_duty_nxt;

  function automatic logic [DUTY_W-1:0] f_target(input logic [LW-1:0] lv);
    logic [PW-1:0] p;
    p = {{DUTY_W{1'b0}}, lv} * PW'(DMAX);
    return DUTY_W'(p / PW'(NT));
  endfunction

  assign w_stick    = (r_scnt == SCW'(SAMPLE_DIV - 1));
  assign w_fstep    = (r_fcnt == FCW'(FADE_DIV - 1));
  assign w_padv     = (r_pdiv == PCW'(PWM_DIV - 1));
  assign w_mode_chg = w_stick && (r_auto != r_sw_s2);
  assign w_target   = f_target(r_level);

  // dn adds the hysteresis margin one bit wider so thresholds near full scale do not wrap
  always_comb begin
    w_up = '0;
    w_dn = '0;
    for (int unsigned i = 0; i < NT; i++) begin
      if (r_adc_s < thr[i*ADC_W +: ADC_W])
        w_up = w_up + (LW+1)'(1);
      if ({1'b0, r_adc_s} < ({1'b0, thr[i*ADC_W +: ADC_W]} + (ADC_W+1)'(HYST)))
        w_dn = w_dn + (LW+1)'(1);
    end
  end

  // Leaving auto forces off; entering auto waits one tick before the rule applies
  always_comb begin
    w_level_nxt = r_level;
    if (w_stick && r_auto && !r_sw_s2) begin
      w_level_nxt = '0;
    end else if (w_stick && r_auto) begin
      if (w_up > {1'b0, r_level})
        w_level_nxt = w_up[LW-1:0];
      else if (w_dn < {1'b0, r_level})
        w_level_nxt = w_dn[LW-1:0];
    end else if (!r_auto && !w_mode_chg && btn) begin
      w_level_nxt = (r_level == LW'(LEVELS - 1)) ? '0 : r_level + LW'(1);
    end
  end

  always_comb begin
    w_duty_nxt = r_duty;
    if (w_fstep) begin
      if (r_duty < w_target)
        w_duty_nxt = r_duty + DUTY_W'(1);
      else if (r_duty > w_target)
        w_duty_nxt = r_duty - DUTY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sw_s1  <= 1'b0;
      r_sw_s2  <= 1'b0;
      r_auto   <= 1'b0;
      r_adc_s  <= '0;
      r_scnt   <= '0;
      r_fcnt   <= '0;
      r_pdiv   <= '0;
      r_level  <= '0;
      r_duty   <= '0;
      r_fading <= 1'b0;
      r_pc     <= '0;
      r_duty_l <= '0;
      r_led    <= 1'b0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
      r_scnt  <= w_stick ? '0 : r_scnt + SCW'(1);
      r_fcnt  <= w_fstep ? '0 : r_fcnt + FCW'(1);
      r_pdiv  <= w_padv  ? '0 : r_pdiv + PCW'(1);
      if (w_stick) begin
        r_auto  <= r_sw_s2;
        r_adc_s <= adc_value;
      end
      r_level  <= w_level_nxt;
      r_duty   <= w_duty_nxt;
      r_fading <= (w_duty_nxt != f_target(w_level_nxt));
      // duty is only latched at the period wrap so each period is glitch-free
      if (w_padv) begin
        if (r_pc == DUTY_W'(DMAX - 1)) begin
          r_pc     <= '0;
          r_duty_l <= r_duty;
        end else begin
          r_pc <= r_pc + DUTY_W'(1);
        end
      end
      r_led <= (r_pc < r_duty_l);
    end
  end

  assign level     = r_level;
  assign duty      = r_duty;
  assign fading    = r_fading;
  assign auto_mode = r_auto;
  assign led_pwm   = r_led;

endmodule

// File: tb/tb_led_lighting_ctrl.sv
// Directed bench for led_lighting_ctrl with fast dividers (sample 4, fade 2, pwm 1)
// and thresholds 15/40/60.
module tb_led_lighting_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn = 1'b0;
  logic       sw = 1'b0;
  logic [6:0] adc_value = '0;
  logic [20:0] thr = {7'd60, 7'd40, 7'd15};
  logic [1:0] level;
  logic [6:0] duty;
  logic       fading;
  logic       auto_mode;
  logic       led_pwm;

  int n_cmp = 0;
  int n_err = 0;

  led_lighting_ctrl #(
    .DUTY_W(7), .LEVELS(4), .ADC_W(7), .HYST(3),
    .SAMPLE_DIV(4), .FADE_DIV(2), .PWM_DIV(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn(btn), .sw(sw),
    .adc_value(adc_value), .thr(thr),
    .level(level), .duty(duty), .fading(fading),
    .auto_mode(auto_mode), .led_pwm(led_pwm)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
  endtask

  task automatic wait_settle(input int lim, output int cyc);
    cyc = 0;
    while (fading === 1'b1 && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic count_hi(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      if (led_pwm === 1'b1) hi++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int hi;
    reset_n = 1'b0;
    tick(4);
    n_cmp++; if (level !== 2'd0)     begin n_err++; $display("FAIL rst_level got %0d want 0", level); end
    n_cmp++; if (duty !== 7'd0)      begin n_err++; $display("FAIL rst_duty got %0d want 0", duty); end
    n_cmp++; if (fading !== 1'b0)    begin n_err++; $display("FAIL rst_fading got %b want 0", fading); end
    n_cmp++; if (auto_mode !== 1'b0) begin n_err++; $display("FAIL rst_auto got %b want 0", auto_mode); end
    n_cmp++; if (led_pwm !== 1'b0)   begin n_err++; $display("FAIL rst_pwm got %b want 0", led_pwm); end
    reset_n = 1'b1;
    count_hi(130, hi);
    n_cmp++; if (hi != 0) begin n_err++; $display("FAIL pwm_off_high got %0d want 0", hi); end
  endtask

  task automatic test_manual();
    int cyc;
    press(); tick(49);
    n_cmp++; if (level !== 2'd1) begin n_err++; $display("FAIL man_l1 got %0d want 1", level); end
    n_cmp++; if ($isunknown(duty) || duty < 24 || duty > 25 || fading !== 1'b1)
      begin n_err++; $display("FAIL man_d1 duty=%0d fading=%b want 24..25/1", duty, fading); end
    press(); tick(49);
    n_cmp++; if (level !== 2'd2) begin n_err++; $display("FAIL man_l2 got %0d want 2", level); end
    n_cmp++; if ($isunknown(duty) || duty < 48 || duty > 50)
      begin n_err++; $display("FAIL man_d2 duty=%0d want 48..50", duty); end
    press(); tick(49);
    n_cmp++; if (level !== 2'd3) begin n_err++; $display("FAIL man_l3 got %0d want 3", level); end
    n_cmp++; if ($isunknown(duty) || duty < 72 || duty > 75)
      begin n_err++; $display("FAIL man_d3 duty=%0d want 72..75", duty); end
    press(); tick(49);
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL man_wrap got %0d want 0", level); end
    n_cmp++; if ($isunknown(duty) || duty < 47 || duty > 51 || fading !== 1'b1)
      begin n_err++; $display("FAIL man_down duty=%0d fading=%b want 47..51/1", duty, fading); end
    wait_settle(300, cyc);
    n_cmp++; if (cyc >= 300 || duty !== 7'd0)
      begin n_err++; $display("FAIL man_settle0 duty=%0d cyc=%0d want 0", duty, cyc); end
    press();
    wait_settle(200, cyc);
    n_cmp++; if (cyc < 83 || cyc > 84)
      begin n_err++; $display("FAIL ramp_len got %0d want 83..84", cyc); end
    n_cmp++; if (duty !== 7'd42 || fading !== 1'b0)
      begin n_err++; $display("FAIL ramp_end duty=%0d fading=%b want 42/0", duty, fading); end
  endtask

  task automatic test_pwm();
    int  hi;
    logic prev;
    bit  found;
    tick(260);
    prev = led_pwm;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (prev === 1'b0 && led_pwm === 1'b1) found = 1;
      else prev = led_pwm;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL pwm_edge no rising edge found"); end
    hi = 0;
    for (int i = 0; i < 127; i++) begin
      if (led_pwm === 1'b1) hi++;
      btn = (i == 3);
      @(negedge clk);
    end
    btn = 1'b0;
    n_cmp++; if (hi != 42) begin n_err++; $display("FAIL pwm_p42 got %0d want 42", hi); end
    count_hi(127, hi);
    n_cmp++; if (hi != 84) begin n_err++; $display("FAIL pwm_p84 got %0d want 84", hi); end
    n_cmp++; if (level !== 2'd2) begin n_err++; $display("FAIL pwm_level got %0d want 2", level); end
    press(); tick(360);
    count_hi(127, hi);
    n_cmp++; if (hi != 127) begin n_err++; $display("FAIL pwm_full got %0d want 127", hi); end
    press(); tick(520);
    count_hi(127, hi);
    n_cmp++; if (hi != 0 || duty !== 7'd0)
      begin n_err++; $display("FAIL pwm_zero high=%0d duty=%0d want 0/0", hi, duty); end
  endtask

  task automatic test_auto();
    adc_value = 7'd10; sw = 1'b1; tick(16);
    n_cmp++; if (auto_mode !== 1'b1) begin n_err++; $display("FAIL auto_on got %b want 1", auto_mode); end
    n_cmp++; if (level !== 2'd3) begin n_err++; $display("FAIL auto_a10 got %0d want 3", level); end
    adc_value = 7'd16; tick(12);
    n_cmp++; if (level !== 2'd3) begin n_err++; $display("FAIL auto_a16 got %0d want 3", level); end
    adc_value = 7'd18; tick(12);
    n_cmp++; if (level !== 2'd2) begin n_err++; $display("FAIL auto_a18 got %0d want 2", level); end
    adc_value = 7'd14; tick(12);
    n_cmp++; if (level !== 2'd3) begin n_err++; $display("FAIL auto_a14 got %0d want 3", level); end
  endtask

  task automatic test_auto_hyst();
    adc_value = 7'd70; tick(12);
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL hyst_a70 got %0d want 0", level); end
    adc_value = 7'd59; tick(12);
    n_cmp++; if (level !== 2'd1) begin n_err++; $display("FAIL hyst_a59 got %0d want 1", level); end
    adc_value = 7'd61; tick(12);
    n_cmp++; if (level !== 2'd1) begin n_err++; $display("FAIL hyst_a61 got %0d want 1", level); end
    adc_value = 7'd63; tick(12);
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL hyst_a63 got %0d want 0", level); end
  endtask

  task automatic test_mode_change();
    int   cyc;
    int   d;
    bit   jump;
    bit   found;
    logic [6:0] prev;
    sw = 1'b0; tick(16);
    n_cmp++; if (auto_mode !== 1'b0 || level !== 2'd0)
      begin n_err++; $display("FAIL mc_manual auto=%b level=%0d want 0/0", auto_mode, level); end
    press(); tick(3); press(); tick(3);
    n_cmp++; if (level !== 2'd2) begin n_err++; $display("FAIL mc_l2 got %0d want 2", level); end
    wait_settle(300, cyc);
    n_cmp++; if (cyc >= 300 || duty !== 7'd84)
      begin n_err++; $display("FAIL mc_d84 duty=%0d cyc=%0d want 84", duty, cyc); end
    adc_value = 7'd70; sw = 1'b1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (auto_mode === 1'b1) found = 1;
    end
    n_cmp++; if (!found || level !== 2'd2)
      begin n_err++; $display("FAIL mc_entry found=%0d level=%0d want 1/2", found, level); end
    jump = 0;
    prev = duty;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      d = int'(duty) - int'(prev);
      if (d > 1 || d < -1) jump = 1;
      prev = duty;
    end
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL mc_auto_l0 got %0d want 0", level); end
    n_cmp++; if (jump || $isunknown(duty) || duty < 76 || duty > 83)
      begin n_err++; $display("FAIL mc_fade duty=%0d jump=%0d want 76..83/0", duty, jump); end
    press(); tick(2);
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL mc_btn_auto got %0d want 0", level); end
    sw = 1'b0; tick(16);
    n_cmp++; if (auto_mode !== 1'b0 || level !== 2'd0)
      begin n_err++; $display("FAIL mc_back auto=%b level=%0d want 0/0", auto_mode, level); end
  endtask

  task automatic test_reset_midfade();
    bit found;
    tick(300);
    press(); tick(2); press(); tick(2); press();
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (duty === 7'd60) found = 1;
      else @(negedge clk);
    end
    n_cmp++; if (!found || fading !== 1'b1)
      begin n_err++; $display("FAIL rf_reach60 found=%0d fading=%b want 1/1", found, fading); end
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (duty !== 7'd0 || level !== 2'd0)
      begin n_err++; $display("FAIL rf_state duty=%0d level=%0d want 0/0", duty, level); end
    n_cmp++; if (led_pwm !== 1'b0 || fading !== 1'b0)
      begin n_err++; $display("FAIL rf_outs pwm=%b fading=%b want 0/0", led_pwm, fading); end
    reset_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_manual();
    test_pwm();
    test_auto();
    test_auto_hyst();
    test_mode_change();
    test_reset_midfade();
    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
